// File: rtl/cache_pkg.sv
// Shared types, geometry constants and byte-merge helper for the L1 data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } cache_state_t;

    localparam int LINE_W         = 256;
    localparam int OFFSET_W       = 5;
    localparam int WORDS_PER_LINE = 8;

    function automatic logic [31:0] merge_bytes(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/l1d_array.sv
// Per-set valid/dirty/tag/data storage; reads are combinational off the flops.
module l1d_array
    import cache_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = 32 - OFFSET_W - S_INDEX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [S_INDEX-1:0] index,
    input  logic              line_we,
    input  logic [LINE_W-1:0] line_wdata,
    input  logic [TAG_W-1:0]  tag_wdata,
    input  logic              word_we,
    input  logic [2:0]        word_sel,
    input  logic [31:0]       word_wdata,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag,
    output logic [LINE_W-1:0] line
);
    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]   valid_vec;
    logic [SETS-1:0]   dirty_vec;
    logic [LINE_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS];

    // Only the status bits are reset; tag and data are qualified by valid.
    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_set
            logic valid_reg;
            logic dirty_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                end else if (index == S_INDEX'(gi)) begin
                    if (line_we) begin
                        valid_reg <= 1'b1;
                        dirty_reg <= 1'b0;
                    end else if (word_we) begin
                        dirty_reg <= 1'b1;
                    end
                end
            end
            assign valid_vec[gi] = valid_reg;
            assign dirty_vec[gi] = dirty_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[index] <= line_wdata;
            tag_mem[index]  <= tag_wdata;
        end else if (word_we) begin
            data_mem[index][{word_sel, 5'b0} +: 32] <= word_wdata;
        end
    end

    assign valid = valid_vec[index];
    assign dirty = dirty_vec[index];
    assign tag   = tag_mem[index];
    assign line  = data_mem[index];

endmodule

// File: rtl/l1d_cache.sv
// Direct-mapped write-back, write-allocate L1 data cache: request latch, FSM and output decode.
module l1d_cache
    import cache_pkg::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_byte_enable,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int TAG_W = 32 - OFFSET_W - S_INDEX;

    cache_state_t state_reg, state_next;

    logic [31:2] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        write_reg;

    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] req_index;
    logic [2:0]         req_word;

    logic              set_valid;
    logic              set_dirty;
    logic [TAG_W-1:0]  set_tag;
    logic [LINE_W-1:0] set_line;
    logic [31:0]       sel_word;
    logic              hit;
    logic              line_we;
    logic              word_we;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^mem_address[1:0];

    assign req_tag   = addr_reg[31 -: TAG_W];
    assign req_index = addr_reg[OFFSET_W +: S_INDEX];
    assign req_word  = addr_reg[4:2];

    l1d_array #(
        .S_INDEX (S_INDEX),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .index      (req_index),
        .line_we    (line_we),
        .line_wdata (pmem_rdata),
        .tag_wdata  (req_tag),
        .word_we    (word_we),
        .word_sel   (req_word),
        .word_wdata (merge_bytes(sel_word, wdata_reg, be_reg)),
        .valid      (set_valid),
        .dirty      (set_dirty),
        .tag        (set_tag),
        .line       (set_line)
    );

    assign sel_word = set_line[{req_word, 5'b0} +: 32];
    assign hit      = set_valid && (set_tag == req_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Request fields are captured once in IDLE and held for the whole miss sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            write_reg <= 1'b0;
        end else if (state_reg == IDLE && (mem_read || mem_write)) begin
            addr_reg  <= mem_address[31:2];
            wdata_reg <= mem_wdata;
            be_reg    <= mem_byte_enable;
            write_reg <= mem_write;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (mem_read || mem_write) state_next = CHECK;
            CHECK: begin
                if (hit)                         state_next = IDLE;
                else if (set_valid && set_dirty) state_next = WRITEBACK;
                else                             state_next = FILL;
            end
            WRITEBACK: if (pmem_resp) state_next = FILL;
            FILL:      if (pmem_resp) state_next = CHECK;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        line_we      = 1'b0;
        word_we      = 1'b0;
        case (state_reg)
            CHECK: begin
                if (hit) begin
                    mem_resp = 1'b1;
                    if (write_reg) word_we   = 1'b1;
                    else           mem_rdata = sel_word;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {set_tag, req_index, 5'b0};
                pmem_wdata   = set_line;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, 5'b0};
                line_we      = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1d_cache.sv
// Bench for l1d_cache: directed table, reset-during-fill sequence and random traffic vs a flat-memory model.
module tb_l1d_cache;
    localparam int S_INDEX = 3;
    localparam int SETS    = 1 << S_INDEX;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [31:0]  mem_wdata = '0;
    logic [3:0]   mem_byte_enable = '0;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int checks   = 0;
    int failures = 0;

    l1d_cache #(.S_INDEX(S_INDEX)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    // Backing memory (line granularity) and the architectural view of memory.
    logic [255:0] backing [logic [31:0]];
    logic [31:0]  ref_mem [logic [31:0]];
    // Which line each set should currently hold, for hit/miss/writeback expectations.
    bit           res_v [SETS];
    bit           res_d [SETS];
    logic [23:0]  res_t [SETS];

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        logic [31:0]  a;
        if (backing.exists(la)) return backing[la];
        for (int w = 0; w < 8; w++) begin
            a = la + 32'(4 * w);
            l[32*w +: 32] = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  wa;
        wa = {a[31:2], 2'b00};
        if (ref_mem.exists(wa)) return ref_mem[wa];
        l = line_of({a[31:5], 5'b0});
        return l[{a[4:2], 5'b0} +: 32];
    endfunction

    function automatic logic [255:0] exp_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_word(la + 32'(4 * w));
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one CPU request and acts as the pmem responder with a fixed response delay.
    task automatic transact(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input int delay,
                            output logic [31:0] rdata, output int cycles,
                            output int nwb, output int nfill,
                            output logic [31:0] wb_addr, output logic [31:0] fill_addr);
        bit           done = 0, stable = 1, zero_ok = 1, excl = 1, wbdata_ok = 1, in_req = 0;
        bit           cur_wr = 0;
        int           wait_cnt = 0;
        logic [31:0]  cur_addr = '0;
        logic [255:0] cur_wdata = '0;
        rdata = '0; cycles = 0; nwb = 0; nfill = 0; wb_addr = '0; fill_addr = '0;
        mem_read = !wr; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        while (!done && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                in_req = 0;
            end
            if (pmem_read && pmem_write) excl = 0;
            if (mem_resp) begin
                rdata = mem_rdata;
                done = 1;
            end else if (mem_rdata !== 32'h0) begin
                zero_ok = 0;
            end
            if (!done && (pmem_read || pmem_write)) begin
                if (!in_req) begin
                    in_req = 1; wait_cnt = 0;
                    cur_addr = pmem_address; cur_wdata = pmem_wdata; cur_wr = pmem_write;
                    if (pmem_write) begin
                        nwb++; wb_addr = pmem_address;
                        if (pmem_wdata !== exp_line(pmem_address)) wbdata_ok = 0;
                    end else begin
                        nfill++; fill_addr = pmem_address;
                    end
                end else begin
                    if (pmem_address !== cur_addr || pmem_wdata !== cur_wdata || pmem_write !== cur_wr)
                        stable = 0;
                    wait_cnt++;
                end
                if (wait_cnt == delay) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) backing[pmem_address] = pmem_wdata;
                    else            pmem_rdata = line_of(pmem_address);
                end
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        chk("req_completes", done, 1'b1);
        chk("pmem_stable", stable, 1'b1);
        chk("rdata_zero_idle", zero_ok, 1'b1);
        chk("pmem_exclusive", excl, 1'b1);
        chk("wb_line_data", wbdata_ok, 1'b1);
        @(posedge clk); #1;
        chk("single_resp", mem_resp, 1'b0);
    endtask

    // One request checked against the model; returns what was observed for extra checks.
    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int delay,
                         output logic [31:0] rdata, output int cycles, output int nwb,
                         output int nfill, output logic [31:0] wb_addr, output logic [31:0] fill_addr);
        int          idx;
        logic [23:0] tg;
        bit          hit, wb;
        int          exp_cyc;
        logic [31:0] exp_rd;
        idx = int'(addr[7:5]);
        tg  = addr[31:8];
        hit = res_v[idx] && res_t[idx] == tg;
        wb  = !hit && res_v[idx] && res_d[idx];
        exp_cyc = hit ? 1 : 2 + (delay + 1) + (wb ? delay + 1 : 0);
        exp_rd  = ref_word(addr);
        transact(wr, addr, wd, be, delay, rdata, cycles, nwb, nfill, wb_addr, fill_addr);
        chk("latency", 32'(cycles), 32'(exp_cyc));
        chk("writebacks", 32'(nwb), wb ? 32'd1 : 32'd0);
        chk("fills", 32'(nfill), hit ? 32'd0 : 32'd1);
        if (wb)   chk("wb_addr", wb_addr, {res_t[idx], addr[7:5], 5'b0});
        if (!hit) chk("fill_addr", fill_addr, {addr[31:5], 5'b0});
        if (!wr)  chk("load_data", rdata, exp_rd);
        res_v[idx] = 1; res_t[idx] = tg;
        if (!hit) res_d[idx] = 0;
        if (wr) begin
            res_d[idx] = 1;
            ref_mem[{addr[31:2], 2'b00}] = merge(exp_rd, wd, be);
        end
        $display("op %s addr=%08h wd=%08h be=%b delay=%0d rdata=%08h cycles=%0d wb=%0d fill=%0d",
                 wr ? "WR" : "RD", addr, wd, be, delay, rdata, cycles, nwb, nfill);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;
        int          exp_cycles;
        int          exp_nwb;
        int          exp_nfill;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_fill_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [255:0] l;
        logic [31:0]  rd, wa, fa, a;
        int           cyc, nwb, nfill;
        bit           seen;

        vecs[0] = '{0, 32'h040, 32'h0,         4'h0, 0,  3, 0, 1, 32'h0,   32'h040, 32'hDEADBEEF};
        vecs[1] = '{0, 32'h04C, 32'h0,         4'h0, 0,  1, 0, 0, 32'h0,   32'h0,   32'h0C0C0C0C};
        vecs[2] = '{1, 32'h044, 32'h11223344,  4'h3, 0,  1, 0, 0, 32'h0,   32'h0,   32'h0};
        vecs[3] = '{0, 32'h044, 32'h0,         4'h0, 0,  1, 0, 0, 32'h0,   32'h0,   32'hAABB3344};
        vecs[4] = '{0, 32'h140, 32'h0,         4'h0, 0,  4, 1, 1, 32'h040, 32'h140, 32'hCAFEF00D};
        vecs[5] = '{1, 32'h140, 32'h01020304,  4'hF, 0,  1, 0, 0, 32'h0,   32'h0,   32'h0};
        vecs[6] = '{0, 32'h040, 32'h0,         4'h0, 10, 24, 1, 1, 32'h140, 32'h040, 32'hDEADBEEF};
        vecs[7] = '{0, 32'h044, 32'h0,         4'h0, 0,  1, 0, 0, 32'h0,   32'h0,   32'hAABB3344};
        vecs[8] = '{0, 32'h140, 32'h0,         4'h0, 10, 13, 0, 1, 32'h0,   32'h140, 32'h01020304};

        l = line_of(32'h040);
        l[31:0] = 32'hDEADBEEF; l[63:32] = 32'hAABBCCDD; l[127:96] = 32'h0C0C0C0C;
        backing[32'h040] = l;
        l = line_of(32'h140);
        l[31:0] = 32'hCAFEF00D;
        backing[32'h140] = l;
        for (int s = 0; s < SETS; s++) begin res_v[s] = 0; res_d[s] = 0; res_t[s] = '0; end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 32'h0);
        chk("rst_pmem_wdata", pmem_wdata, 256'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].delay,
                  rd, cyc, nwb, nfill, wa, fa);
            chk("vec_cycles", 32'(cyc), 32'(vecs[i].exp_cycles));
            chk("vec_nwb", 32'(nwb), 32'(vecs[i].exp_nwb));
            chk("vec_nfill", 32'(nfill), 32'(vecs[i].exp_nfill));
            if (vecs[i].exp_nwb > 0)   chk("vec_wb_addr", wa, vecs[i].exp_wb_addr);
            if (vecs[i].exp_nfill > 0) chk("vec_fill_addr", fa, vecs[i].exp_fill_addr);
            if (!vecs[i].wr)           chk("vec_rdata", rd, vecs[i].exp_rdata);
        end

        // Reset while a fill is outstanding.
        seen = 0;
        mem_read = 1'b1; mem_address = 32'h240;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (pmem_read) seen = 1;
        end
        chk("rst_reached_fill", seen, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_fill_pmem_read", pmem_read, 1'b0);
        chk("rst_fill_pmem_write", pmem_write, 1'b0);
        chk("rst_fill_mem_resp", mem_resp, 1'b0);
        chk("rst_fill_pmem_address", pmem_address, 32'h0);
        mem_read = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_mem_resp", mem_resp, 1'b0);
        rst = 1'b0;
        $display("op RST during fill of 00000240 pmem_read_dropped=%0d", !pmem_read);
        for (int s = 0; s < SETS; s++) begin res_v[s] = 0; res_d[s] = 0; end
        ref_mem.delete();
        @(posedge clk); #1;
        do_op(0, 32'h040, 32'h0, 4'h0, 0, rd, cyc, nwb, nfill, wa, fa);
        chk("reread_misses", 32'(nfill), 32'd1);
        chk("reread_data", rd, 32'hDEADBEEF);

        for (int i = 0; i < 250; i++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            do_op(bit'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), rd, cyc, nwb, nfill, wa, fa);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1d_cache.md
# l1d_cache

Direct-mapped, write-back, write-allocate L1 data cache that answers the pipeline's data-memory requests (read/write strobes, word address, write data, byte enable), holding each request until it asserts `mem_resp`. It sits between the MEM stage and physical memory. Misses are serviced through a 256-bit cacheline port; a dirty victim is written back before each fill.

## Interface
- `S_INDEX`, default 3: index bits; 2^S_INDEX sets of one 256-bit line each.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  CPU load request; held until `mem_resp`.
- `mem_write`  in  1  CPU store request; held until `mem_resp`.
- `mem_address`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  store data, already lane-aligned.
- `mem_byte_enable`  in  4  store byte mask; bit i enables byte lane i.
- `mem_rdata`  out  32  load data; valid only while `mem_resp`=1, otherwise 0.
- `mem_resp`  out  1  one-cycle completion pulse.
- `pmem_read`  out  1  line fill request; held until `pmem_resp`.
- `pmem_write`  out  1  line writeback request; held until `pmem_resp`.
- `pmem_address`  out  32  line address; bits [4:0] = 0.
- `pmem_wdata`  out  256  victim line.
- `pmem_rdata`  in  256  fill line.
- `pmem_resp`  in  1  memory completion pulse.

## Operation
- Address split: offset [4:0], with word select [4:2]; index [4+S_INDEX:5]; tag [31:5+S_INDEX].
- Per set: `valid`, `dirty`, tag and 256-bit data, all in flip-flops. Reset clears only `valid` and `dirty`.
- FSM states: IDLE, CHECK, WRITEBACK, FILL.
- IDLE: when `mem_read` or `mem_write` is high, latch address, wdata and byte enable, then go to CHECK. If both strobes are high, the request is a write.
- CHECK: hit means valid and tag equal.
  - Read hit: drive `mem_rdata` = selected word and `mem_resp`=1; go to IDLE.
  - Write hit: merge the enabled bytes into the word, set `dirty`, pulse `mem_resp`; go to IDLE.
  - Miss on a valid, dirty set: go to WRITEBACK.
  - Any other miss: go to FILL.
- WRITEBACK: `pmem_write`=1, `pmem_address`={victim tag, index, 5'b0}, `pmem_wdata`=victim line. All held stable until `pmem_resp`; then go to FILL.
- FILL: `pmem_read`=1, `pmem_address`={latched tag, index, 5'b0}.
  - On `pmem_resp`: store `pmem_rdata`, set tag, set `valid`=1, clear `dirty`; go to CHECK, which then hits.
- `pmem_read` and `pmem_write` are never both high.
- The initiator deasserts its strobe in the cycle after `mem_resp`. A strobe still high in IDLE is a new request.
- Reset mid-operation: the FSM returns to IDLE immediately (asynchronous). The pending request is dropped, all lines are invalidated, and pmem strobes fall without waiting for `pmem_resp`.

## Timing
- Reset values: `mem_resp`=0, `mem_rdata`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0; state IDLE.
- Hit: request sampled at edge 0; `mem_resp` is high during cycle 1 (latency 1).
- Clean miss: CHECK(1) + FILL(F) + CHECK(1). With `pmem_resp` on the first FILL cycle, `mem_resp` arrives in cycle 3.
- Dirty miss: adds the WRITEBACK cycles (W) before FILL.
- `mem_rdata` and `mem_resp` are combinational from the state and the registered arrays. pmem outputs are decoded from state and registers only, with no combinational path from `pmem_resp`.

## Structure
- `cache_pkg` holds:
  - `cache_state_t` enum: IDLE, CHECK, WRITEBACK, FILL.
  - Localparams for line width (256), offset width (5) and words per line (8).
  - Function `merge_bytes(word, wdata, be)`.
- Sub-module `l1d_array`: valid, dirty, tag and data storage, with synchronous write ports and an asynchronous clear of valid/dirty. The top level holds the FSM, latches and output muxing.

## Test plan
- Reset, then read 0x40; memory returns a line with word0=0xDEADBEEF one cycle after `pmem_read` -> `pmem_address`=0x40, `mem_rdata`=0xDEADBEEF, `mem_resp` in cycle 3, no `pmem_write`.
- Read 0x4C after the fill -> `mem_resp` in cycle 1 with word3 of the line, pmem strobes stay 0.
- Write 0x44, data 0x11223344, be 4'b0011, over old word 0xAABBCCDD -> a subsequent read of 0x44 returns 0xAABB3344.
- Then read 0x140 (same index, S_INDEX=3) -> `pmem_write` at 0x40 with the merged line, then `pmem_read` at 0x140; correct word returned.
- Hold `pmem_resp` low for 10 cycles during WRITEBACK and during FILL -> address, wdata and strobes are stable every cycle; exactly one `mem_resp`.
- Assert `rst` during FILL -> `pmem_read` drops in the same cycle, no `mem_resp`; a re-read of 0x40 misses again.
